// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader.
// - state_t: loader FSM states.
//   The encoding is fixed so that debug probes decode the same way everywhere.
// - WORD_BYTES: bytes per instruction word.
// - BYTE_INDEX_WIDTH: width of the byte-within-word counter.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int WORD_BYTES       = 4;
  localparam int BYTE_INDEX_WIDTH = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer
// Assembles four accepted bytes into one little-endian 32-bit word.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   accept         a byte on in_byte is taken on this edge
//   clear          drop any partial word and restart at byte 0
//   in_byte        byte from the source
//   word           assembled word, with the byte being accepted already merged in
//   wordComplete   high when the byte being accepted is the last of its word
import imem_loader_pkg::*;

module imem_loader_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        wordComplete
);

  logic [BYTE_INDEX_WIDTH-1:0] byte_index;
  logic [31:0]                 shift_word;

  // Merging the incoming byte combinationally lets the parent capture the
  // complete word on the same edge that accepts its final byte.
  always_comb begin
    word = shift_word;
    if (accept) begin
      word[{byte_index, 3'b000} +: 8] = in_byte;
    end
  end

  assign wordComplete = accept && (byte_index == BYTE_INDEX_WIDTH'(WORD_BYTES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_index <= '0;
      shift_word <= '0;
    end else if (clear) begin
      byte_index <= '0;
      shift_word <= '0;
    end else if (accept) begin
      shift_word <= word;
      // The index wraps back to 0 after the final byte of a word.
      byte_index <= byte_index + BYTE_INDEX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Fills the instruction memory from a byte stream.
// Bytes are packed into little-endian words.
// Each word is written once, at consecutive word-aligned addresses starting
// at BASE_WORD. The datapath is held frozen while a load is in progress.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, length       begin a load of `length` words (sampled in IDLE only)
//   inValid/inData      byte source
//   inReady             a byte can be accepted this cycle
//   memWrite            one-cycle write strobe, qualifies memAddress/memData
//   memAddress/memData  byte address and data of the word being written
//   cpuHold             freeze pc/fetch while collecting and writing
//   busy                high in any state but IDLE
//   done                one-cycle pulse at the end of a load
//   wordsWritten        words written by the current or most recent load
import imem_loader_pkg::*;

module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_WORD  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  inValid,
  input  logic [7:0]            inData,
  output logic                  inReady,
  output logic                  memWrite,
  output logic [31:0]           memAddress,
  output logic [31:0]           memData,
  output logic                  cpuHold,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wordsWritten
);

  localparam logic [ADDR_WIDTH-1:0] BASE_INDEX = ADDR_WIDTH'(BASE_WORD);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   length_reg;
  logic [ADDR_WIDTH-1:0] word_index;
  logic [ADDR_WIDTH:0]   words_written;
  logic [31:0]           mem_address_reg;
  logic [31:0]           mem_data_reg;
  logic [ADDR_WIDTH-1:0] write_word_addr;
  logic [31:0]           packed_word;
  logic                  word_complete;
  logic                  byte_accept;
  logic                  load_start;

  assign byte_accept = inValid && (state == COLLECT);
  assign load_start  = start && (state == IDLE);

  // Word addresses wrap modulo the memory size; an oversized load is the
  // caller's problem.
  assign write_word_addr = BASE_INDEX + word_index;

  imem_loader_byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .accept       (byte_accept),
    .clear        (load_start),
    .in_byte      (inData),
    .word         (packed_word),
    .wordComplete (word_complete)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    inReady    = 1'b0;
    memWrite   = 1'b0;
    cpuHold    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (length == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        inReady = 1'b1;
        cpuHold = 1'b1;
        if (word_complete) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        memWrite = 1'b1;
        cpuHold  = 1'b1;
        if (words_written + (ADDR_WIDTH+1)'(1) == length_reg) begin
          state_next = DONE;
        end else begin
          state_next = COLLECT;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and data are captured as the last byte arrives.
  // They stay put until the next word completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      length_reg      <= '0;
      word_index      <= '0;
      words_written   <= '0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            length_reg    <= length;
            word_index    <= '0;
            words_written <= '0;
          end
        end
        COLLECT: begin
          if (word_complete) begin
            mem_data_reg    <= packed_word;
            mem_address_reg <= 32'({write_word_addr, 2'b00});
          end
        end
        WRITE: begin
          word_index    <= word_index + ADDR_WIDTH'(1);
          words_written <= words_written + (ADDR_WIDTH+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign memAddress   = mem_address_reg;
  assign memData      = mem_data_reg;
  assign wordsWritten = words_written;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader on the write side of the instruction memory: the datapath only reads that memory, and this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one write per word to the instruction memory at incrementing word-aligned addresses.
- Asserts cpuHold while loading, so the datapath's pc/fetch stays frozen until the program is complete.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory (capacity 2^ADDR_WIDTH words).
- BASE_WORD, 0, first word index written; byte address = BASE_WORD*4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- length  in  ADDR_WIDTH+1  number of words to load; latched on accepted start.
- inValid  in  1  byte source has valid data.
- inData  in  8  byte from source.
- inReady  out  1  loader can accept a byte this cycle.
- memWrite  out  1  instruction-memory write strobe.
- memAddress  out  32  byte address of the word being written (low 2 bits always 0).
- memData  out  32  assembled word.
- cpuHold  out  1  freeze the datapath (pc and fetch) while high.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- wordsWritten  out  ADDR_WIDTH+1  words written in the current or last load.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - inReady, memWrite, cpuHold, busy, done = 0.
  - memAddress, memData, wordsWritten = 0.
  - byte index = 0.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - inReady = 0.
  - start=1 and length!=0 → COLLECT. Latch length, word index = 0, byte index = 0, wordsWritten = 0.
  - start=1 and length==0 → DONE. No write occurs.
- COLLECT:
  - inReady = 1, cpuHold = 1.
  - A byte is accepted only on the edge where inValid && inReady.
  - Byte k (k = 0..3) goes to memData[8k+7:8k] (little-endian).
  - After the byte with index 3 is accepted → WRITE. Byte index wraps to 0.
  - inValid low: stay, no state change.
- WRITE:
  - Exactly one cycle. memWrite = 1, inReady = 0, cpuHold = 1.
  - memAddress = (BASE_WORD + word index) * 4, zero-extended to 32 bits.
  - memData is stable during this cycle.
  - Next edge: word index++, wordsWritten++.
  - If the new count equals the latched length → DONE, else → COLLECT.
- DONE:
  - done = 1 for one cycle. cpuHold = 0, inReady = 0.
  - Next state: IDLE.
- Throughput: 4 accepted bytes + 1 WRITE cycle per word. Minimum 5 cycles/word with inValid held high.
- start while busy: ignored. Changes to length after it is latched: ignored.
- Address overflow: BASE_WORD + length > 2^ADDR_WIDTH is a caller error. The word index wraps modulo 2^ADDR_WIDTH; there is no error flag.
- Reset mid-load: abort immediately.
  - A partial word is discarded; no memWrite is issued for it.
  - cpuHold drops asynchronously.
- memData and memAddress hold their last values outside WRITE. Consumers must qualify them with memWrite.

Decomposition:
- Shared package: state encoding (IDLE=0, COLLECT=1, WRITE=2, DONE=3) and the constant WORD_BYTES=4.
- One natural sub-module, byte_packer:
  - Holds the 2-bit byte index and the 32-bit shift/insert register.
  - Inputs: accept, clear. Outputs: word, wordComplete.
- The FSM, address counter and handshake stay in imem_loader.

Test Plan:
- Basic load: reset; start, length=2; bytes 13,00,00,00,93,00,10,00 with inValid always high → exactly two writes:
  - addr 0x0, data 0x00000013.
  - addr 0x4, data 0x00100093.
  - done pulse one cycle after the second write; wordsWritten=2; cpuHold high from the first COLLECT cycle until DONE.
- Gappy source: same data with inValid toggling 1,0,1,0 → identical writes, no byte lost or duplicated, inReady never high in WRITE.
- length=0: start → no memWrite, done pulses the cycle after start, cpuHold stays 0.
- start while busy: second start during COLLECT with length=5 → ignored; load completes after the original length=1.
- Reset mid-word: after 2 of 4 bytes, assert reset → memWrite never asserted, outputs 0. Then a new load of length=1, bytes EF,BE,AD,DE → write addr 0x0, data 0xDEADBEEF.
- BASE_WORD=4, ADDR_WIDTH=3, length=5 → addresses 0x10, 0x14, 0x18, 0x1C, then wraps to 0x00.
